// File: rtl/rc6_out_unloader.sv
// rc6_out_unloader
//   Takes the 128-bit result block from the RC6 round data register and
//   streams it out as four 32-bit words on a valid/ready handshake. One
//   extra block can be parked in a pending register so the core can finish
//   the next block while the current one drains.
//
// Ports
//   inClk        clock, rising edge
//   inReset      asynchronous active-high reset
//   inLoad       one-cycle strobe, inData holds a finished block
//   inData       block, A in [31:0] .. D in [127:96]
//   outCanLoad   pending slot empty, a load now is guaranteed accepted
//   outValid     outWord is valid
//   inReady      sink accepts outWord this cycle
//   outWord      current output word
//   outLast      high with the 4th word of a block
//   outOverflow  one-cycle pulse, a load was dropped
//
// state | meaning
// ------+-----------------------------------------
// IDLE  | no block in the output register
// SEND  | output register holds a block being drained
module rc6_out_unloader #(
   parameter bit LSW_FIRST = 1'b1
) (
   input  logic          inClk,
   input  logic          inReset,
   input  logic          inLoad,
   input  logic [127:0]  inData,
   output logic          outCanLoad,
   output logic          outValid,
   input  logic          inReady,
   output logic [31:0]   outWord,
   output logic          outLast,
   output logic          outOverflow
);

   typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

   state_t        r_state;
   logic [127:0]  r_sr;
   logic [127:0]  r_pr;
   logic [1:0]    r_cnt;
   logic          r_pf;
   logic          r_valid;
   logic          r_ovf;

   logic          w_xfer;
   logic          w_last_xfer;
   logic [1:0]    w_idx;

   assign w_xfer      = r_valid & inReady;
   assign w_last_xfer = w_xfer & (r_cnt == 2'd3);
   // MSW-first order walks the words 3..0, which is the bitwise inverse of CNT.
   assign w_idx       = LSW_FIRST ? r_cnt : ~r_cnt;

   assign outValid    = r_valid;
   assign outWord     = r_sr[{w_idx, 5'b0} +: 32];
   assign outLast     = r_valid & (r_cnt == 2'd3);
   assign outOverflow = r_ovf;
   assign outCanLoad  = ~r_pf;

   always_ff @(posedge inClk or posedge inReset) begin
      if (inReset) begin
         r_state <= ST_IDLE;
         r_sr    <= '0;
         r_pr    <= '0;
         r_cnt   <= 2'd0;
         r_pf    <= 1'b0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_ovf <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (inLoad) begin
                  r_sr    <= inData;
                  r_cnt   <= 2'd0;
                  r_state <= ST_SEND;
                  r_valid <= 1'b1;
               end
            end
            ST_SEND: begin
               if (w_last_xfer) begin
                  if (r_pf) begin
                     // Pending block moves up; a coincident load refills the slot.
                     r_sr  <= r_pr;
                     r_cnt <= 2'd0;
                     if (inLoad) r_pr <= inData;
                     else        r_pf <= 1'b0;
                  end else if (inLoad) begin
                     r_sr  <= inData;
                     r_cnt <= 2'd0;
                  end else begin
                     r_cnt   <= 2'd0;
                     r_state <= ST_IDLE;
                     r_valid <= 1'b0;
                  end
               end else begin
                  if (w_xfer) r_cnt <= r_cnt + 2'd1;
                  if (inLoad) begin
                     if (!r_pf) begin
                        r_pr <= inData;
                        r_pf <= 1'b1;
                     end else begin
                        r_ovf <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc6_out_unloader.sv
module tb_rc6_out_unloader;

   logic          inClk = 1'b0;
   logic          inReset;
   logic          inLoad;
   logic [127:0]  inData;
   logic          inReady;

   logic          o1_can, o1_valid, o1_last, o1_ovf;
   logic [31:0]   o1_word;
   logic          o0_can, o0_valid, o0_last, o0_ovf;
   logic [31:0]   o0_word;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [127:0] BLK_A = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] BLK_X = 128'hD0D0D0D3_C0C0C0C2_B0B0B0B1_A0A0A0A0;
   localparam logic [127:0] BLK_Y = 128'h1D1D1D1D_1C1C1C1C_1B1B1B1B_1A1A1A1A;
   localparam logic [127:0] BLK_Z = 128'h2D2D2D2D_2C2C2C2C_2B2B2B2B_2A2A2A2A;
   localparam logic [127:0] BLK_W = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;

   rc6_out_unloader #(.LSW_FIRST(1'b1)) dut1 (
      .inClk(inClk), .inReset(inReset), .inLoad(inLoad), .inData(inData),
      .outCanLoad(o1_can), .outValid(o1_valid), .inReady(inReady),
      .outWord(o1_word), .outLast(o1_last), .outOverflow(o1_ovf)
   );

   rc6_out_unloader #(.LSW_FIRST(1'b0)) dut0 (
      .inClk(inClk), .inReset(inReset), .inLoad(inLoad), .inData(inData),
      .outCanLoad(o0_can), .outValid(o0_valid), .inReady(inReady),
      .outWord(o0_word), .outLast(o0_last), .outOverflow(o0_ovf)
   );

   always #5 inClk = ~inClk;

   task automatic tick();
      @(posedge inClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wsel(input logic [127:0] b, input int k, input bit lsw);
      int i;
      i = lsw ? k : 3 - k;
      return b[i*32 +: 32];
   endfunction

   // Checks the LSW-first instance is presenting word k of blk.
   task automatic chk_w1(input string tag, input logic [127:0] blk, input int k);
      chk($sformatf("%s_v%0d", tag, k), {127'b0, o1_valid}, 128'd1);
      chk($sformatf("%s_w%0d", tag, k), {96'b0, o1_word}, {96'b0, wsel(blk, k, 1'b1)});
      chk($sformatf("%s_l%0d", tag, k), {127'b0, o1_last}, {127'b0, k == 3});
   endtask

   // Streams all four words with inReady high, starting from word 0 showing.
   task automatic stream1(input string tag, input logic [127:0] blk);
      for (int k = 0; k < 4; k++) begin
         chk_w1(tag, blk, k);
         tick();
      end
   endtask

   initial begin
      inReset = 1'b1;
      inLoad  = 1'b0;
      inData  = '0;
      inReady = 1'b0;
      tick(); tick();
      chk("rst_valid", {127'b0, o1_valid}, 128'd0);
      chk("rst_word",  {96'b0, o1_word},   128'd0);
      chk("rst_last",  {127'b0, o1_last},  128'd0);
      chk("rst_ovf",   {127'b0, o1_ovf},   128'd0);
      chk("rst_can",   {127'b0, o1_can},   128'd1);
      inReset = 1'b0;
      tick();

      // single block, LSW first, ready held high
      inReady = 1'b1;
      inLoad  = 1'b1;
      inData  = BLK_A;
      tick();
      inLoad  = 1'b0;
      stream1("single", BLK_A);
      chk("single_idle", {127'b0, o1_valid}, 128'd0);
      chk("single_idle_last", {127'b0, o1_last}, 128'd0);
      tick();

      // MSW-first instance, ready toggling 1,0,1,0,... over 7 cycles
      inLoad = 1'b1;
      inData = BLK_A;
      tick();
      inLoad = 1'b0;
      for (int c = 0; c < 7; c++) begin
         inReady = (c % 2 == 0);
         chk($sformatf("msw_v%0d", c), {127'b0, o0_valid}, 128'd1);
         chk($sformatf("msw_w%0d", c), {96'b0, o0_word}, {96'b0, wsel(BLK_A, (c + 1) / 2, 1'b0)});
         chk($sformatf("msw_l%0d", c), {127'b0, o0_last}, {127'b0, ((c + 1) / 2) == 3});
         tick();
      end
      chk("msw_idle", {127'b0, o0_valid}, 128'd0);
      chk("msw_first_word", {96'b0, wsel(BLK_A, 0, 1'b0)}, 128'h44444444);

      // back-to-back: Y loaded during transfer of X word 1
      inReady = 1'b1;
      inLoad  = 1'b1;
      inData  = BLK_X;
      tick();
      inLoad  = 1'b0;
      chk_w1("b2b_x", BLK_X, 0);
      tick();
      chk_w1("b2b_x", BLK_X, 1);
      chk("b2b_can_before", {127'b0, o1_can}, 128'd1);
      inLoad = 1'b1;
      inData = BLK_Y;
      tick();
      inLoad = 1'b0;
      chk_w1("b2b_x", BLK_X, 2);
      chk("b2b_can_pend", {127'b0, o1_can}, 128'd0);
      tick();
      chk_w1("b2b_x", BLK_X, 3);
      chk("b2b_can_pend3", {127'b0, o1_can}, 128'd0);
      tick();
      chk("b2b_can_after", {127'b0, o1_can}, 128'd1);
      stream1("b2b_y", BLK_Y);
      chk("b2b_idle", {127'b0, o1_valid}, 128'd0);

      // overflow: X, Y, Z with sink stalled; Z is dropped
      inReady = 1'b0;
      inLoad  = 1'b1;
      inData  = BLK_X;
      tick();
      inData  = BLK_Y;
      tick();
      chk("ovf_none_y", {127'b0, o1_ovf}, 128'd0);
      chk("ovf_can_y", {127'b0, o1_can}, 128'd0);
      inData  = BLK_Z;
      tick();
      inLoad  = 1'b0;
      chk("ovf_pulse", {127'b0, o1_ovf}, 128'd1);
      tick();
      chk("ovf_pulse_end", {127'b0, o1_ovf}, 128'd0);
      inReady = 1'b1;
      stream1("ovf_x", BLK_X);
      stream1("ovf_y", BLK_Y);
      chk("ovf_no_z", {127'b0, o1_valid}, 128'd0);

      // load of Z coincides with last-word transfer of X while Y is pending
      inReady = 1'b0;
      inLoad  = 1'b1;
      inData  = BLK_X;
      tick();
      inData  = BLK_Y;
      tick();
      inLoad  = 1'b0;
      inReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk_w1("sim_x", BLK_X, k);
         tick();
      end
      chk_w1("sim_x", BLK_X, 3);
      inLoad = 1'b1;
      inData = BLK_Z;
      tick();
      inLoad = 1'b0;
      chk("sim_ovf", {127'b0, o1_ovf}, 128'd0);
      chk("sim_can", {127'b0, o1_can}, 128'd0);
      stream1("sim_y", BLK_Y);
      chk("sim_can_z", {127'b0, o1_can}, 128'd1);
      stream1("sim_z", BLK_Z);
      chk("sim_idle", {127'b0, o1_valid}, 128'd0);

      // async reset during word 2 with a block pending
      inReady = 1'b0;
      inLoad  = 1'b1;
      inData  = BLK_X;
      tick();
      inData  = BLK_Y;
      tick();
      inLoad  = 1'b0;
      inReady = 1'b1;
      tick();
      tick();
      chk_w1("ar_x", BLK_X, 2);
      chk("ar_can_pre", {127'b0, o1_can}, 128'd0);
      #2;
      inReset = 1'b1;
      #1;
      chk("ar_valid", {127'b0, o1_valid}, 128'd0);
      chk("ar_word",  {96'b0, o1_word},   128'd0);
      chk("ar_last",  {127'b0, o1_last},  128'd0);
      chk("ar_can",   {127'b0, o1_can},   128'd1);
      #2;
      inReset = 1'b0;
      inLoad  = 1'b1;
      inData  = BLK_W;
      tick();
      inLoad  = 1'b0;
      stream1("ar_w", BLK_W);
      chk("ar_idle", {127'b0, o1_valid}, 128'd0);
      chk("ar_no_y", {127'b0, o1_can}, 128'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
